joystick_serializer: RTL and testbench

//  Target (shift-register) end of the serial joystick bus. The same bus is read by the decoder on the

---
 rtl/joystick_serializer_if.sv | 33 +++
 rtl/joystick_serializer.sv | 112 +++++++++++
 tb/tb_joystick_serializer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/joystick_serializer_if.sv
// Serial joystick bus between a host-side master and the
// shift-register target: pad state, load/clock strobes, data.
interface joystick_serializer_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] joy1;
    logic [WIDTH-1:0] joy2;
    logic             joyCk;
    logic             joyLd;
    logic             joyD;
    logic             busy;
    logic             frame;

    modport master (
        output joy1,
        output joy2,
        output joyCk,
        output joyLd,
        input  joyD,
        input  busy,
        input  frame
    );

    modport slave (
        input  joy1,
        input  joy2,
        input  joyCk,
        input  joyLd,
        output joyD,
        output busy,
        output frame
    );
endinterface

// File: rtl/joystick_serializer.sv
// 74HC165-style target for the serial joystick bus: loads two
// pads in negative logic and shifts them out on joyD.
module joystick_serializer #(
    parameter int   WIDTH       = 12,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL        = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    joystick_serializer_if.slave  bus
);
    localparam int NB = 2 * WIDTH;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
    localparam logic [CW-1:0] FULL = CW'(NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] ck_sync_q;
    logic [SYNC_STAGES-1:0] ld_sync_q;
    logic                   ck_prev_q;
    state_t                 state_q;
    logic [NB-1:0]          sr_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;
    logic                   frame_q;

    logic          ck_s;
    logic          ld_s;
    logic          ck_rise;
    logic [NB-1:0] load_d;
    logic [NB-1:0] shift_d;

    assign ck_s    = ck_sync_q[SYNC_STAGES-1];
    assign ld_s    = ld_sync_q[SYNC_STAGES-1];
    assign ck_rise = ck_s & ~ck_prev_q;
    assign load_d  = ~{bus.joy2, bus.joy1};
    assign shift_d = {FILL, sr_q[NB-1:1]};

    // Synchronise master strobes; idle-high reset avoids a fake edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_sync_q <= '1;
            ld_sync_q <= '1;
            ck_prev_q <= 1'b1;
        end else begin
            ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], bus.joyCk};
            ld_sync_q <= {ld_sync_q[SYNC_STAGES-2:0], bus.joyLd};
            ck_prev_q <= ck_s;
        end
    end

    // Load/shift FSM; load always dominates a coincident clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!ld_s) state_q <= LOAD;
                end
                LOAD: begin
                    sr_q  <= load_d;
                    cnt_q <= '0;
                    if (ld_s) begin
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!ld_s) begin
                        busy_q  <= 1'b0;
                        state_q <= LOAD;
                    end else if (ck_rise) begin
                        sr_q  <= shift_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            frame_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!ld_s) begin
                        state_q <= LOAD;
                    end else if (ck_rise) begin
                        sr_q <= shift_d;
                        if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.joyD  = sr_q[0];
    assign bus.busy  = busy_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_joystick_serializer.sv
// Directed bench for joystick_serializer: frames, overrun,
// restart, transparent load and mid-frame reset.
module tb_joystick_serializer;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   frame_cnt;
    logic [31:0] bits;
    int   f0;

    joystick_serializer_if #(.WIDTH(12)) bus ();

    joystick_serializer #(
        .WIDTH(12),
        .SYNC_STAGES(2),
        .FILL(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count frame pulses, sampled away from the active edge.
    always @(negedge clock) begin
        if (bus.frame === 1'b1) frame_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load_pulse();
        bus.joyLd = 1'b0;
        ticks(5);
        bus.joyLd = 1'b1;
        ticks(5);
    endtask

    task automatic ck_pulse();
        bus.joyCk = 1'b1;
        ticks(5);
        bus.joyCk = 1'b0;
        ticks(5);
    endtask

    task automatic shift_bits(input int n, output logic [31:0] b);
        b = '0;
        for (int i = 0; i < n; i++) begin
            b[i] = bus.joyD;
            ck_pulse();
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        frame_cnt = 0;
        reset     = 1'b0;
        bus.joy1  = '0;
        bus.joy2  = '0;
        bus.joyCk = 1'b0;
        bus.joyLd = 1'b1;
        ticks(3);
        chk("rst_joyD", {31'd0, bus.joyD}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_frame", {31'd0, bus.frame}, 32'd0);
        reset = 1'b1;
        ticks(3);

        // 1: only U on pad 1 pressed
        bus.joy1 = 12'h001;
        bus.joy2 = 12'h000;
        load_pulse();
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        f0 = frame_cnt;
        shift_bits(24, bits);
        chk("t1_bits", bits, 32'h00FF_FFFE);
        chk("t1_frame", frame_cnt - f0, 1);
        chk("t1_busy_end", {31'd0, bus.busy}, 32'd0);

        // 2: pad1 all pressed, pad2 = 0A5
        bus.joy1 = 12'hFFF;
        bus.joy2 = 12'h0A5;
        load_pulse();
        f0 = frame_cnt;
        bus.joy1 = 12'h000;
        bus.joy2 = 12'h000;
        shift_bits(24, bits);
        chk("t2_bits", bits, 32'h00F5_A000);
        chk("t2_frame", frame_cnt - f0, 1);

        // 3: overrun clocks read FILL with no extra frame
        f0 = frame_cnt;
        shift_bits(4, bits);
        chk("t3_bits", bits, 32'h0000_000F);
        chk("t3_joyD", {31'd0, bus.joyD}, 32'd1);
        chk("t3_frame", frame_cnt - f0, 0);
        chk("t3_busy", {31'd0, bus.busy}, 32'd0);

        // 4: abort after 10 bits, restart with new data
        bus.joy1 = 12'h001;
        load_pulse();
        f0 = frame_cnt;
        shift_bits(10, bits);
        chk("t4_part", bits, 32'h0000_03FE);
        chk("t4_busy_mid", {31'd0, bus.busy}, 32'd1);
        bus.joy1 = 12'h002;
        load_pulse();
        chk("t4_noframe", frame_cnt - f0, 0);
        shift_bits(24, bits);
        chk("t4_bits", bits, 32'h00FF_FFFD);
        chk("t4_frame", frame_cnt - f0, 1);

        // 5: held load is transparent, clocks ignored
        bus.joy1 = 12'h000;
        bus.joyLd = 1'b0;
        ticks(5);
        chk("t5_busy", {31'd0, bus.busy}, 32'd0);
        bus.joy1 = 12'h001;
        ticks(1);
        chk("t5_follow0", {31'd0, bus.joyD}, 32'd0);
        bus.joy1 = 12'h000;
        ticks(1);
        chk("t5_follow1", {31'd0, bus.joyD}, 32'd1);
        bus.joy1 = 12'h001;
        ck_pulse();
        ck_pulse();
        chk("t5_ckign", {31'd0, bus.joyD}, 32'd0);
        bus.joyLd = 1'b1;
        ticks(5);
        chk("t5_bit0", {31'd0, bus.joyD}, 32'd0);

        // 6: reset mid-frame
        bus.joy1 = 12'h004;
        load_pulse();
        f0 = frame_cnt;
        shift_bits(2, bits);
        chk("t6_pre_joyD", {31'd0, bus.joyD}, 32'd0);
        chk("t6_pre_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_joyD", {31'd0, bus.joyD}, 32'd1);
        chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        ticks(2);
        reset = 1'b1;
        ticks(2);
        shift_bits(3, bits);
        chk("t6_idle_bits", bits, 32'h0000_0007);
        chk("t6_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_frame", frame_cnt - f0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
